// File: rtl/car_lane_sprite.sv
// One car sprite on one road row: erase the old box, step with wrap-around,
// redraw in the latched colour, hold for a frame delay, then pulse done.
module car_lane_sprite #(
    parameter int W_LOG2  = 3,
    parameter int H_LOG2  = 2,
    parameter int X_START = 87,
    parameter int Y_ROW   = 90,
    parameter int X_MIN   = 26,
    parameter int X_MAX   = 127,
    parameter int STEP    = 1,
    parameter int DIR     = 0,
    parameter int DELAY   = 41670
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] colour,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour_out,
    output logic [7:0] x_pos,
    output logic       busy,
    output logic       done
);

    localparam int PCW = W_LOG2 + H_LOG2;
    localparam int DCW = (DELAY > 1) ? $clog2(DELAY) : 1;

    localparam logic [PCW-1:0] PC_LAST = '1;
    localparam logic [DCW-1:0] DC_LAST = DCW'(DELAY - 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_DRAW,
        S_HOLD,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [DCW-1:0] dc_q, dc_d;
    logic [7:0]     x_pos_q, x_pos_d;
    logic [2:0]     col_q, col_d;

    logic [7:0]     x_moved;
    logic [7:0]     x_pix;
    logic [6:0]     y_pix;

    // Wrap decision uses a 9-bit sum so x_pos+STEP never aliases past 255.
    generate
        if (DIR == 0) begin : g_right
            logic [8:0] x_fwd;
            always_comb begin
                x_fwd = {1'b0, x_pos_q} + 9'(STEP);
                if (x_fwd > 9'(X_MAX)) begin
                    x_moved = 8'(X_MIN);
                end else begin
                    x_moved = x_fwd[7:0];
                end
            end
        end else begin : g_left
            always_comb begin
                if ({1'b0, x_pos_q} < 9'(X_MIN + STEP)) begin
                    x_moved = 8'(X_MAX);
                end else begin
                    x_moved = x_pos_q - 8'(STEP);
                end
            end
        end
    endgenerate

    // Low pc bits walk across a row, high bits walk down the rows.
    assign x_pix = x_pos_q + 8'(pc_q[W_LOG2-1:0]);
    assign y_pix = 7'(Y_ROW) + 7'(pc_q[PCW-1:W_LOG2]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dc_d    = dc_q;
        x_pos_d = x_pos_q;
        col_d   = col_q;
        case (state_q)
            S_WAIT: begin
                if (en) begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                pc_d = pc_q + 1'b1;
                if (pc_q == PC_LAST) begin
                    pc_d    = '0;
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                x_pos_d = x_moved;
                col_d   = colour;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                pc_d = pc_q + 1'b1;
                if (pc_q == PC_LAST) begin
                    pc_d    = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                dc_d = dc_q + 1'b1;
                if (dc_q == DC_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                dc_d    = '0;
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
                pc_d    = '0;
                dc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            pc_q    <= '0;
            dc_q    <= '0;
            x_pos_q <= 8'(X_START);
            col_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dc_q    <= dc_d;
            x_pos_q <= x_pos_d;
            col_q   <= col_d;
        end
    end

    // Outputs decode straight from state and registers so reset clears them at once.
    always_comb begin
        plot       = 1'b0;
        x          = x_pos_q;
        y          = 7'(Y_ROW);
        colour_out = 3'b000;
        case (state_q)
            S_ERASE: begin
                plot = 1'b1;
                x    = x_pix;
                y    = y_pix;
            end
            S_DRAW: begin
                plot       = 1'b1;
                x          = x_pix;
                y          = y_pix;
                colour_out = col_q;
            end
            default: begin
                plot = 1'b0;
            end
        endcase
    end

    assign x_pos = x_pos_q;
    assign busy  = (state_q != S_WAIT);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_car_lane_sprite.sv
// Four lanes with different parameters driven by shared en/colour/reset and
// checked every cycle against a timeline model of the redraw sequence.
module tb_car_lane_sprite;

    localparam int NI = 4;
    localparam int P_W    [NI] = '{3, 3, 3, 2};
    localparam int P_H    [NI] = '{2, 2, 2, 1};
    localparam int P_XS   [NI] = '{87, 127, 29, 87};
    localparam int P_STEP [NI] = '{1, 1, 4, 1};
    localparam int P_DIR  [NI] = '{0, 0, 1, 0};
    localparam int YR   = 90;
    localparam int XMIN = 26;
    localparam int XMAX = 127;
    localparam int DLY  = 10;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] colour;

    logic       plot_w [NI];
    logic [7:0] x_w    [NI];
    logic [6:0] y_w    [NI];
    logic [2:0] co_w   [NI];
    logic [7:0] xpos_w [NI];
    logic       busy_w [NI];
    logic       done_w [NI];

    car_lane_sprite #(.W_LOG2(3), .H_LOG2(2), .X_START(87), .Y_ROW(90), .X_MIN(26),
                      .X_MAX(127), .STEP(1), .DIR(0), .DELAY(10)) u_a (
        .clk(clk), .reset(reset), .en(en), .colour(colour),
        .plot(plot_w[0]), .x(x_w[0]), .y(y_w[0]), .colour_out(co_w[0]),
        .x_pos(xpos_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    car_lane_sprite #(.W_LOG2(3), .H_LOG2(2), .X_START(127), .Y_ROW(90), .X_MIN(26),
                      .X_MAX(127), .STEP(1), .DIR(0), .DELAY(10)) u_b (
        .clk(clk), .reset(reset), .en(en), .colour(colour),
        .plot(plot_w[1]), .x(x_w[1]), .y(y_w[1]), .colour_out(co_w[1]),
        .x_pos(xpos_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    car_lane_sprite #(.W_LOG2(3), .H_LOG2(2), .X_START(29), .Y_ROW(90), .X_MIN(26),
                      .X_MAX(127), .STEP(4), .DIR(1), .DELAY(10)) u_c (
        .clk(clk), .reset(reset), .en(en), .colour(colour),
        .plot(plot_w[2]), .x(x_w[2]), .y(y_w[2]), .colour_out(co_w[2]),
        .x_pos(xpos_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    car_lane_sprite #(.W_LOG2(2), .H_LOG2(1), .X_START(87), .Y_ROW(90), .X_MIN(26),
                      .X_MAX(127), .STEP(1), .DIR(0), .DELAY(10)) u_d (
        .clk(clk), .reset(reset), .en(en), .colour(colour),
        .plot(plot_w[3]), .x(x_w[3]), .y(y_w[3]), .colour_out(co_w[3]),
        .x_pos(xpos_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    int ecnt = 0;
    int e_en = 0;
    int phase = 0;
    bit chk_on = 1'b0;

    // Model: m_t is the cycle number inside the current update (0 = idle).
    int m_t   [NI];
    int m_x   [NI];
    int m_col [NI];

    // Statistics gathered by the monitor for the hand-computed checks.
    int done_cyc [NI] = '{default: -1};
    int plots_p1 [NI] = '{default: 0};
    int b_xmin = 255, b_xmax = 0;
    int d_ymin = 127, d_ymax = 0;
    int a_done_p2 = 0, a_c010_p2 = 0, a_c110_p2 = 0;

    task automatic chk(input string nm, input int idx, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s inst%0d t=%0t got %0d expected %0d", nm, idx, $time, got, exp);
        end
    endtask

    function automatic int moved(input int i, input int xp);
        if (P_DIR[i] == 0) return (xp + P_STEP[i] > XMAX) ? XMIN : xp + P_STEP[i];
        return (xp < XMIN + P_STEP[i]) ? XMAX : xp - P_STEP[i];
    endfunction

    always @(posedge clk) ecnt <= ecnt + 1;

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_t[i] = 0; m_x[i] = P_XS[i]; m_col[i] = 0;
        end
        forever begin
            @(posedge clk or posedge reset);
            for (int i = 0; i < NI; i++) begin
                int n, total;
                n = 1 << (P_W[i] + P_H[i]);
                total = 2 * n + 2 + DLY;
                if (reset) begin
                    m_t[i] = 0; m_x[i] = P_XS[i]; m_col[i] = 0;
                end else if (m_t[i] == 0) begin
                    if (en) m_t[i] = 1;
                end else begin
                    if (m_t[i] == n + 1) begin
                        m_col[i] = int'(colour);
                        m_x[i] = moved(i, m_x[i]);
                    end
                    m_t[i] = (m_t[i] == total) ? 0 : m_t[i] + 1;
                end
            end
        end
    end

    // Compare process: every output of every lane on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int i = 0; i < NI; i++) begin
                    int n, t, total, p, wm, eplot, ex, ey, eco;
                    n = 1 << (P_W[i] + P_H[i]);
                    total = 2 * n + 2 + DLY;
                    wm = (1 << P_W[i]) - 1;
                    t = m_t[i];
                    eplot = 0; ex = m_x[i]; ey = YR; eco = 0;
                    if (t >= 1 && t <= n) begin
                        p = t - 1;
                        eplot = 1;
                        ex = (m_x[i] + (p & wm)) % 256;
                        ey = (YR + (p >> P_W[i])) % 128;
                    end else if (t >= n + 2 && t <= 2 * n + 1) begin
                        p = t - n - 2;
                        eplot = 1;
                        ex = (m_x[i] + (p & wm)) % 256;
                        ey = (YR + (p >> P_W[i])) % 128;
                        eco = m_col[i];
                    end
                    chk("plot", i, int'(plot_w[i]), eplot);
                    chk("x", i, int'(x_w[i]), ex);
                    chk("y", i, int'(y_w[i]), ey);
                    chk("colour_out", i, int'(co_w[i]), eco);
                    chk("x_pos", i, int'(xpos_w[i]), m_x[i]);
                    chk("busy", i, int'(busy_w[i]), (t != 0) ? 1 : 0);
                    chk("done", i, int'(done_w[i]), (t == total) ? 1 : 0);

                    if (done_w[i])
                        $display("inst%0d update complete at edge %0d, x_pos=%0d", i, ecnt, xpos_w[i]);
                    if (phase == 1) begin
                        if (plot_w[i]) plots_p1[i]++;
                        if (done_w[i] && done_cyc[i] < 0) done_cyc[i] = ecnt - e_en + 1;
                        if (i == 1 && plot_w[i] && co_w[i] != 3'b000) begin
                            if (int'(x_w[i]) < b_xmin) b_xmin = int'(x_w[i]);
                            if (int'(x_w[i]) > b_xmax) b_xmax = int'(x_w[i]);
                        end
                        if (i == 3 && plot_w[i]) begin
                            if (int'(y_w[i]) < d_ymin) d_ymin = int'(y_w[i]);
                            if (int'(y_w[i]) > d_ymax) d_ymax = int'(y_w[i]);
                        end
                    end
                    if (phase == 2 && i == 0) begin
                        if (done_w[i]) a_done_p2++;
                        if (plot_w[i] && co_w[i] == 3'b010) a_c010_p2++;
                        if (plot_w[i] && co_w[i] == 3'b110) a_c110_p2++;
                    end
                end
            end
        end
    end

    // All tasks assume they start 2 ns after a rising edge.
    task automatic wait_edge(input int target);
        while (ecnt < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_en();
        en = 1'b1;
        @(posedge clk);
        #2;
        en = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        bit any_busy;
        k = 0;
        any_busy = 1'b1;
        while (k < 600 && any_busy) begin
            @(posedge clk);
            #2;
            k++;
            any_busy = 1'b0;
            for (int i = 0; i < NI; i++) if (busy_w[i]) any_busy = 1'b1;
        end
        chk("idle_timeout", 0, (k < 600) ? 1 : 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        colour = 3'b000;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        chk_on = 1'b1;
        #1;
        chk("rst_x", 0, int'(x_w[0]), 87);
        chk("rst_y", 0, int'(y_w[0]), 90);
        chk("rst_plot", 0, int'(plot_w[0]), 0);
        chk("rst_busy", 0, int'(busy_w[0]), 0);
        chk("rst_xpos", 2, int'(xpos_w[2]), 29);

        // Single update on every lane, colour 101.
        @(posedge clk);
        #2;
        colour = 3'b101;
        phase = 1;
        e_en = ecnt + 1;
        pulse_en();
        wait_idle();
        phase = 0;
        chk("done_cycle", 0, done_cyc[0], 76);
        chk("plot_count", 0, plots_p1[0], 64);
        chk("xpos_upd1", 0, int'(xpos_w[0]), 88);
        chk("wrap_right", 1, int'(xpos_w[1]), 26);
        chk("draw_xmin", 1, b_xmin, 26);
        chk("draw_xmax", 1, b_xmax, 33);
        chk("wrap_left", 2, int'(xpos_w[2]), 127);
        chk("done_cycle", 3, done_cyc[3], 28);
        chk("plot_count", 3, plots_p1[3], 16);
        chk("ymin", 3, d_ymin, 90);
        chk("ymax", 3, d_ymax, 91);

        // en pulses during ERASE/DRAW/HOLD of lane 0; colour changes after MOVE.
        colour = 3'b010;
        phase = 2;
        e_en = ecnt + 1;
        pulse_en();
        wait_edge(e_en + 4);
        pulse_en();
        wait_edge(e_en + 35);
        colour = 3'b110;
        wait_edge(e_en + 39);
        pulse_en();
        wait_edge(e_en + 69);
        pulse_en();
        wait_idle();
        phase = 0;
        chk("done_count", 0, a_done_p2, 1);
        chk("xpos_upd2", 0, int'(xpos_w[0]), 89);
        chk("draw_col010", 0, a_c010_p2, 32);
        chk("draw_col110", 0, a_c110_p2, 0);
        chk("step_left", 2, int'(xpos_w[2]), 123);

        // Asynchronous reset in the middle of DRAW (pc=10) on lane 0.
        @(posedge clk);
        #2;
        e_en = ecnt + 1;
        pulse_en();
        wait_edge(e_en + 43);
        chk("mid_plot", 0, int'(plot_w[0]), 1);
        chk("mid_x", 0, int'(x_w[0]), 92);
        chk("mid_y", 0, int'(y_w[0]), 91);
        chk("mid_col", 0, int'(co_w[0]), 6);
        reset = 1'b1;
        #1;
        chk("arst_plot", 0, int'(plot_w[0]), 0);
        chk("arst_busy", 0, int'(busy_w[0]), 0);
        chk("arst_xpos", 0, int'(xpos_w[0]), 87);
        chk("arst_x", 0, int'(x_w[0]), 87);
        chk("arst_col", 0, int'(co_w[0]), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // One more update from the reset position.
        @(posedge clk);
        #2;
        colour = 3'b011;
        pulse_en();
        wait_idle();
        chk("xpos_post", 0, int'(xpos_w[0]), 88);
        chk("xpos_post", 2, int'(xpos_w[2]), 127);

        @(posedge clk);
        #2;
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
